// File: rtl/led_blinker_array_mmio.sv
// N_CH-channel memory-mapped LED blinker sharing one millisecond prescaler.
// Define LED_BLINK_CNT_EN to add per-channel saturating toggle counters at 2+N_CH+ch.
module led_blinker_array_mmio #(
  parameter int N_CH        = 4,            // 1..16
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int IW          = 16            // 1..16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cs,
  input  logic            wr_en,
  input  logic            rd_en,
  input  logic [4:0]      address,
  input  logic [15:0]     wr_data,
  output logic [15:0]     rd_data,
  output logic [N_CH-1:0] led
);

  localparam int PRE_TC = CLK_FREQ_HZ / 1000 - 1;
  localparam int PW     = (PRE_TC > 0) ? $clog2(PRE_TC + 1) : 1;

  logic [PW-1:0]   presc_q, presc_d;
  logic            tick;
  logic [N_CH-1:0] ctrl_q, ctrl_d;
  logic [N_CH-1:0] pol_q, pol_d;
  logic [N_CH-1:0] r_q, r_d;
  logic [N_CH-1:0] led_q, led_d;
  logic [N_CH-1:0] toggled;
  logic [IW-1:0]   interval_q [N_CH];
  logic [IW-1:0]   interval_d [N_CH];
  logic [IW-1:0]   cnt_q [N_CH];
  logic [IW-1:0]   cnt_d [N_CH];
  logic [15:0]     rd_data_q, rd_data_d;
  logic [15:0]     rd_mux;
  logic [31:0]     addr_w;
  logic            wr_stb;
  logic            rd_stb;
  logic            unused_bits;

`ifdef LED_BLINK_CNT_EN
  logic [15:0] tcnt_q [N_CH];
  logic [15:0] tcnt_d [N_CH];
`endif

  assign addr_w      = {27'd0, address};
  assign wr_stb      = cs & wr_en;
  assign rd_stb      = cs & rd_en;
  assign unused_bits = ^{wr_data, toggled};

  always_comb begin
    tick    = (presc_q == PW'(PRE_TC));
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ctrl_d     = ctrl_q;
    pol_d      = pol_q;
    interval_d = interval_q;
    r_d        = r_q;
    cnt_d      = cnt_q;
    toggled    = '0;

    if (wr_stb && addr_w == 32'd0) ctrl_d = wr_data[N_CH-1:0];
    if (wr_stb && addr_w == 32'd1) pol_d  = wr_data[N_CH-1:0];

    for (int i = 0; i < N_CH; i++) begin
      if (wr_stb && addr_w == 32'(i + 2)) interval_d[i] = wr_data[IW-1:0];

      // Priority: disable, enable edge, interval write, steady-on, tick.
      if (!ctrl_d[i]) begin
        r_d[i]   = 1'b0;
        cnt_d[i] = '0;
      end else if (!ctrl_q[i]) begin
        r_d[i]   = 1'b1;
        cnt_d[i] = '0;
      end else if (wr_stb && addr_w == 32'(i + 2)) begin
        cnt_d[i] = '0;
      end else if (interval_q[i] == '0) begin
        r_d[i]   = 1'b1;
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == interval_q[i] - 1'b1) begin
          r_d[i]     = ~r_q[i];
          cnt_d[i]   = '0;
          toggled[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

`ifdef LED_BLINK_CNT_EN
  always_comb begin
    tcnt_d = tcnt_q;
    for (int i = 0; i < N_CH; i++) begin
      if (wr_stb && addr_w == 32'(2 + N_CH + i)) begin
        tcnt_d[i] = '0;
      end else if (toggled[i] && tcnt_q[i] != 16'hFFFF) begin
        tcnt_d[i] = tcnt_q[i] + 16'd1;
      end
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    if (addr_w == 32'd0) rd_mux = 16'(ctrl_q);
    if (addr_w == 32'd1) rd_mux = 16'(pol_q);
    for (int i = 0; i < N_CH; i++) begin
      if (addr_w == 32'(i + 2)) rd_mux = 16'(interval_q[i]);
`ifdef LED_BLINK_CNT_EN
      if (addr_w == 32'(2 + N_CH + i)) rd_mux = tcnt_q[i];
`endif
    end
    rd_data_d = rd_stb ? rd_mux : rd_data_q;
    led_d     = r_q ^ pol_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      ctrl_q    <= '0;
      pol_q     <= '0;
      r_q       <= '0;
      led_q     <= '0;
      rd_data_q <= '0;
      // NOTE: the interval and counter arrays are small register files that must read 0 after reset, so they are reset here.
      for (int i = 0; i < N_CH; i++) begin
        interval_q[i] <= '0;
        cnt_q[i]      <= '0;
`ifdef LED_BLINK_CNT_EN
        tcnt_q[i]     <= '0;
`endif
      end
    end else begin
      presc_q    <= presc_d;
      ctrl_q     <= ctrl_d;
      pol_q      <= pol_d;
      r_q        <= r_d;
      led_q      <= led_d;
      rd_data_q  <= rd_data_d;
      interval_q <= interval_d;
      cnt_q      <= cnt_d;
`ifdef LED_BLINK_CNT_EN
      tcnt_q     <= tcnt_d;
`endif
    end
  end

  assign rd_data = rd_data_q;
  assign led     = led_q;

endmodule
